// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter and the
// seven-segment display stage that consumes its packed result.
package bcd_pkg;

    localparam int          DIGITS  = 4;
    localparam int          BCD_MAX = 9999;
    localparam logic [15:0] BCD_SAT = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    // Conditional +3, wrapping inside the 4-bit digit
    always_comb begin
        q_o = d_i;
        if (d_i >= 4'd5) begin
            q_o = d_i + 4'd3;
        end else begin
            q_o = d_i;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// The result is held between conversions so a display mux sees a steady value.
module bin2bcd_seq #(
    parameter int WIDTH   = 14,
    parameter int DIGITS  = bcd_pkg::DIGITS,
    parameter int BCD_MAX = bcd_pkg::BCD_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    bin,
    input  logic                start,
    output logic [4*DIGITS-1:0] bcd,
    output logic                done,
    output logic                busy,
    output logic                ovf
);

    import bcd_pkg::*;

    localparam int               BW    = 4 * DIGITS;
    localparam int               CW    = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(BCD_MAX);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [BW-1:0]    scr_q;
    logic [BW-1:0]    scr_d;
    logic [BW-1:0]    adj_s;
    logic             sat_q;
    logic [BW-1:0]    bcd_q;
    logic             done_q;
    logic             busy_q;
    logic             ovf_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .d_i (scr_q[4*g +: 4]),
            .q_o (adj_s[4*g +: 4])
        );
    end

    // The corrected digits and binary register shift left as one long word
    assign scr_d = {adj_s[BW-2:0], bin_q[WIDTH-1]};
    assign bin_d = {bin_q[WIDTH-2:0], 1'b0};

    // Control FSM with all datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            sat_q   <= 1'b0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= (bin > MAX_W);
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    scr_q <= scr_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // Saturated inputs still run the full shift so latency never varies
                    bcd_q   <= sat_q ? {DIGITS{4'h9}} : scr_q;
                    ovf_q   <= sat_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: latency, boundaries,
// saturation, ignored starts, back-to-back acceptance and async reset.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic [13:0] bin;
    logic        start;
    logic [15:0] bcd;
    logic        done;
    logic        busy;
    logic        ovf;

    int checks;
    int errors;

    bin2bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .bin   (bin),
        .start (start),
        .bcd   (bcd),
        .done  (done),
        .busy  (busy),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start with value v and wait for done; returns at the
    // negedge where done is high. Optional stray starts (bin=777) at ign_a/ign_b.
    task automatic run(input string tag, input logic [13:0] v, input logic [15:0] eb,
                       input logic eo, input int ign_a, input int ign_b);
        int lat;
        int bcyc;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bcyc  = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            @(negedge clk);
            lat++;
            start = (lat == ign_a) || (lat == ign_b);
            bin   = start ? 14'd777 : v;
        end
        start = 1'b0;
        chk({tag, "_lat"},  lat,  32'd15);
        chk({tag, "_busy"}, bcyc, 32'd15);
        chk({tag, "_bcd"},  bcd,  eb);
        chk({tag, "_ovf"},  ovf,  eo);
    endtask

    initial begin
        int lat;
        int dcnt;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bin    = 14'd0;
        start  = 1'b0;

        #12;
        chk("rst_bcd",  bcd,  32'h0);
        chk("rst_done", done, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ovf",  ovf,  32'd0);
        @(negedge clk);
        rst = 1'b1;

        run("c1234", 14'd1234, 16'h1234, 1'b0, 0, 0);
        dcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("hold_done_cnt", dcnt, 32'd0);
        chk("hold_bcd", bcd, 32'h1234);

        run("c0",     14'd0,     16'h0000, 1'b0, 0, 0);
        run("c9",     14'd9,     16'h0009, 1'b0, 0, 0);
        run("c9999",  14'd9999,  16'h9999, 1'b0, 0, 0);
        run("c10000", 14'd10000, 16'h9999, 1'b1, 0, 0);
        run("c16383", 14'd16383, 16'h9999, 1'b1, 0, 0);
        run("c42",    14'd42,    16'h0042, 1'b0, 0, 0);

        run("ign500", 14'd500, 16'h0500, 1'b0, 3, 14);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ign_extra_done", dcnt, 32'd0);
        chk("ign_hold_bcd", bcd, 32'h0500);

        run("b2b_first", 14'd2024, 16'h2024, 1'b0, 0, 0);
        bin   = 14'd321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", busy, 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_gap", lat, 32'd16);
        chk("b2b_bcd", bcd, 32'h0321);

        @(negedge clk);
        bin   = 14'd1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_bcd",  bcd,  32'h0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_done", done, 32'd0);
        chk("arst_ovf",  ovf,  32'd0);
        @(negedge clk);
        rst = 1'b1;
        run("c88", 14'd88, 16'h0088, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
